// File: rtl/led_pkg.sv
// ============================================================================
//  Module      : led_pkg
//  Description : Shared types and constants for the LED brightness blocks
//                (ramp generator, PWM driver, prescalers).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_pkg;

   // Default widths shared with the PWM LED driver
   localparam int DEF_LEVEL_BITS = 8;
   localparam int DEF_TICK_BITS  = 16;

   // Ramp sequencer states
   typedef enum logic [1:0] {
      RISE    = 2'd0,
      HOLD_HI = 2'd1,
      FALL    = 2'd2,
      HOLD_LO = 2'd3
   } ramp_state_t;

   // Full-scale brightness code for a given level width
   function automatic int level_max(input int bits);
      return (1 << bits) - 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
//  Module      : tick_prescaler
//  Description : Step-period prescaler. Counts 0..period-1 while enabled and
//                fires a one-cycle tick in the final count. period=0 behaves
//                like period=1. Count is compared against the live period.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler
   import led_pkg::*;
#(
   parameter int TICK_BITS = DEF_TICK_BITS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_en,
   input  logic [TICK_BITS-1:0] i_period,
   output logic                 o_tick
);

   localparam logic [TICK_BITS-1:0] c_one = {{(TICK_BITS-1){1'b0}}, 1'b1};

   logic [TICK_BITS-1:0] r_cnt;
   logic                 w_last;

   // Periods of 0 and 1 both tick every enabled cycle; avoids underflow of period-1
   assign w_last = (i_period <= c_one) || (r_cnt >= (i_period - c_one));
   assign o_tick = i_en & w_last;

   // Prescale counter: frozen while paused, wraps to 0 on the tick
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_en) begin
         if (w_last) r_cnt <= '0;
         else        r_cnt <= r_cnt + c_one;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ramp_gen.sv
// ============================================================================
//  Module      : ramp_gen
//  Description : Brightness-level sequencer for the PWM LED driver. Produces a
//                sawtooth or triangle ramp with programmable step period and
//                end holds, plus a step strobe, direction flag and cycle-done
//                pulse. Optional gamma (square-law) output mapping is enabled
//                by defining RAMP_GEN_GAMMA_EN, adding one clock of latency to
//                level, step strobe and cycle-done.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ramp_gen
   import led_pkg::*;
#(
   parameter int LEVEL_BITS = DEF_LEVEL_BITS,
   parameter int TICK_BITS  = DEF_TICK_BITS,
   parameter int HOLD_STEPS = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_en,
   input  logic                  i_mode_tri,
   input  logic [TICK_BITS-1:0]  i_period,
   output logic [LEVEL_BITS-1:0] o_level,
   output logic                  o_step_stb,
   output logic                  o_dir,
   output logic                  o_cycle_done
);

   localparam int HB = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
   localparam logic [LEVEL_BITS-1:0] c_max      = LEVEL_BITS'(level_max(LEVEL_BITS));
   localparam logic [LEVEL_BITS-1:0] c_lvl_one  = {{(LEVEL_BITS-1){1'b0}}, 1'b1};
   localparam logic [HB-1:0]         c_hold_last = HB'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);
   localparam logic [HB-1:0]         c_hold_one  = {{(HB-1){1'b0}}, 1'b1};

   ramp_state_t           r_state, w_state_nxt;
   logic [LEVEL_BITS-1:0] r_lin,   w_lin_nxt;
   logic [HB-1:0]         r_hold,  w_hold_nxt;
   logic                  r_stb,   w_stb_nxt;
   logic                  r_done,  w_done_nxt;
   logic                  w_tick;
   logic                  w_hold_last;

   tick_prescaler #(
      .TICK_BITS (TICK_BITS)
   ) u_prescaler (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_en     (i_en),
      .i_period (i_period),
      .o_tick   (w_tick)
   );

   // A hold of one step ends on its first tick
   assign w_hold_last = (HOLD_STEPS <= 1) || (r_hold == c_hold_last);

   // Sequencer state, linear level, hold count and registered pulses
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= RISE;
         r_lin   <= '0;
         r_hold  <= '0;
         r_stb   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_lin   <= w_lin_nxt;
         r_hold  <= w_hold_nxt;
         r_stb   <= w_stb_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Next-state and level logic; everything advances only on a prescaler tick
   always_comb begin
      w_state_nxt = r_state;
      w_lin_nxt   = r_lin;
      w_hold_nxt  = r_hold;
      w_stb_nxt   = 1'b0;
      w_done_nxt  = 1'b0;
      if (w_tick) begin
         case (r_state)
            RISE: begin
               if (r_lin == c_max) begin
                  // mode_tri is only consulted at the top of the rise
                  if (!i_mode_tri) begin
                     w_lin_nxt  = '0;
                     w_stb_nxt  = 1'b1;
                     w_done_nxt = 1'b1;
                  end else if (HOLD_STEPS == 0) begin
                     w_state_nxt = FALL;
                  end else begin
                     w_state_nxt = HOLD_HI;
                     w_hold_nxt  = '0;
                  end
               end else begin
                  w_lin_nxt = r_lin + c_lvl_one;
                  w_stb_nxt = 1'b1;
               end
            end
            HOLD_HI: begin
               if (w_hold_last) begin
                  w_state_nxt = FALL;
                  w_hold_nxt  = '0;
               end else begin
                  w_hold_nxt = r_hold + c_hold_one;
               end
            end
            FALL: begin
               if (r_lin == '0) begin
                  if (HOLD_STEPS == 0) begin
                     w_state_nxt = RISE;
                     w_done_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = HOLD_LO;
                     w_hold_nxt  = '0;
                  end
               end else begin
                  w_lin_nxt = r_lin - c_lvl_one;
                  w_stb_nxt = 1'b1;
               end
            end
            HOLD_LO: begin
               if (w_hold_last) begin
                  w_state_nxt = RISE;
                  w_hold_nxt  = '0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_hold_nxt = r_hold + c_hold_one;
               end
            end
            default: begin
               w_state_nxt = RISE;
               w_hold_nxt  = '0;
            end
         endcase
      end
   end

   // Direction follows the registered state: high while rising or holding high
   assign o_dir = (r_state == RISE) || (r_state == HOLD_HI);

`ifdef RAMP_GEN_GAMMA_EN
   logic [2*LEVEL_BITS-1:0] w_sq;
   logic [LEVEL_BITS-1:0]   r_gamma;
   logic                    r_stb_d;
   logic                    r_done_d;

   assign w_sq = {{LEVEL_BITS{1'b0}}, r_lin} * {{LEVEL_BITS{1'b0}}, r_lin};

   // Square-law output stage; pulses delayed to stay aligned with the level
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_gamma  <= '0;
         r_stb_d  <= 1'b0;
         r_done_d <= 1'b0;
      end else begin
         r_gamma  <= w_sq[2*LEVEL_BITS-1:LEVEL_BITS];
         r_stb_d  <= r_stb;
         r_done_d <= r_done;
      end
   end

   assign o_level      = r_gamma;
   assign o_step_stb   = r_stb_d;
   assign o_cycle_done = r_done_d;
`else
   assign o_level      = r_lin;
   assign o_step_stb   = r_stb;
   assign o_cycle_done = r_done;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ramp_gen.sv
// ============================================================================
//  Module      : tb_ramp_gen
//  Description : Directed self-checking bench for ramp_gen (linear output
//                build) with LEVEL_BITS=4, HOLD_STEPS=2.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ramp_gen;

   localparam int LB = 4;
   localparam int TB = 8;
   localparam int HS = 2;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          en       = 1'b0;
   logic          mode_tri = 1'b0;
   logic [TB-1:0] period   = 8'd3;
   logic [LB-1:0] level;
   logic          step_stb;
   logic          dir;
   logic          cycle_done;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ramp_gen #(
      .LEVEL_BITS (LB),
      .TICK_BITS  (TB),
      .HOLD_STEPS (HS)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_en         (en),
      .i_mode_tri   (mode_tri),
      .i_period     (period),
      .o_level      (level),
      .o_step_stb   (step_stb),
      .o_dir        (dir),
      .o_cycle_done (cycle_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance clocks until a step strobe is seen; n = clocks taken
   task automatic wait_stb(input int max, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!step_stb && n < max);
      if (!step_stb) chk("stb_timeout", {31'd0, step_stb}, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int t;
      int e_lvl, e_stb, e_dir, e_done;

      // ---- reset held for 3 clocks with en=1
      en = 1'b1; rst_n = 1'b0; period = 8'd3; mode_tri = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_level", level, 0);
      chk("rst_stb",   step_stb, 0);
      chk("rst_done",  cycle_done, 0);
      chk("rst_dir",   dir, 1);

      // ---- release: first strobe after period clocks, then sawtooth
      rst_n = 1'b1;
      wait_stb(10, n);
      chk("first_stb_lat", n, 3);
      chk("first_level",   level, 1);
      chk("first_done",    cycle_done, 0);
      for (int k = 2; k <= 16; k++) begin
         wait_stb(10, n);
         chk("saw_spacing", n, 3);
         chk("saw_level",   level, k % 16);
         chk("saw_done",    cycle_done, (k == 16) ? 1 : 0);
         chk("saw_dir",     dir, 1);
      end

      // ---- triangle at period=1, starting from level 0 in RISE
      period = 8'd1; mode_tri = 1'b1;
      for (int j = 1; j <= 36; j++) begin
         @(negedge clk);
         e_done = 0;
         if (j <= 15)      begin e_lvl = j;      e_stb = 1; e_dir = 1; end
         else if (j <= 17) begin e_lvl = 15;     e_stb = 0; e_dir = 1; end
         else if (j == 18) begin e_lvl = 15;     e_stb = 0; e_dir = 0; end
         else if (j <= 33) begin e_lvl = 33 - j; e_stb = 1; e_dir = 0; end
         else if (j <= 35) begin e_lvl = 0;      e_stb = 0; e_dir = 0; end
         else              begin e_lvl = 0;      e_stb = 0; e_dir = 1; e_done = 1; end
         chk("tri_level", level, e_lvl);
         chk("tri_stb",   step_stb, e_stb);
         chk("tri_dir",   dir, e_dir);
         chk("tri_done",  cycle_done, e_done);
      end

      // ---- pause at level 7 with prescaler mid-count (period 4, count 2)
      period = 8'd4;
      for (int k = 1; k <= 7; k++) wait_stb(10, n);
      chk("pre_pause_level", level, 7);
      repeat (2) @(negedge clk);
      en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("pause_level", level, 7);
         chk("pause_stb",   step_stb, 0);
      end
      en = 1'b1;
      wait_stb(10, n);
      chk("resume_lat",   n, 2);
      chk("resume_level", level, 8);

      // ---- period=0 behaves like period=1
      period = 8'd0;
      for (int k = 9; k <= 11; k++) begin
         wait_stb(5, n);
         chk("p0_spacing", n, 1);
         chk("p0_level",   level, k);
      end

      // ---- clear mode_tri during FALL: finish triangle, then sawtooth
      period = 8'd1;
      t = 0;
      while (dir !== 1'b0 && t < 100) begin @(negedge clk); t++; end
      chk("fall_reached", dir, 0);
      mode_tri = 1'b0;
      t = 0;
      while (cycle_done !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      chk("tri_end_done",  cycle_done, 1);
      chk("tri_end_level", level, 0);
      chk("tri_end_dir",   dir, 1);
      for (int k = 1; k <= 16; k++) begin
         wait_stb(5, n);
         chk("saw2_spacing", n, 1);
         chk("saw2_level",   level, k % 16);
         chk("saw2_done",    cycle_done, (k == 16) ? 1 : 0);
      end

      // ---- reset at level 12 while falling
      mode_tri = 1'b1;
      t = 0;
      while (!(dir === 1'b0 && level === 4'd12) && t < 100) begin @(negedge clk); t++; end
      chk("fall12_dir",   dir, 0);
      chk("fall12_level", level, 12);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_level", level, 0);
      chk("midrst_dir",   dir, 1);
      chk("midrst_stb",   step_stb, 0);
      chk("midrst_done",  cycle_done, 0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
